// File: rtl/rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_arbiter_pkg
// Description : Shared read-path definitions: arbiter state encoding,
//               requester count, default burst-length width and a small
//               one-hot to index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_arbiter_pkg;

    // Arbiter states: waiting for requests, command outstanding, data phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam int c_NUM_REQ   = 4;
    localparam int c_LEN_WIDTH = 16;

    // Index of the set bit of a one-hot 4-bit vector (0 when empty)
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_arbiter_if
// Description : Read-arbiter bundle: requester requests/grants/strobes and
//               the command handshake towards the DDR controller.
//               master = the arbiter, slave = requesters + controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rd_arbiter_if
    import rd_arbiter_pkg::*;
#(
    parameter int LEN_WIDTH = c_LEN_WIDTH
);

    logic                 rreq1, rreq2, rreq3, rreq4;
    logic [LEN_WIDTH-1:0] ddr_rd_len;
    logic                 rd_opera_en_1, rd_opera_en_2, rd_opera_en_3, rd_opera_en_4;
    logic                 ddr_rdata_en1, ddr_rdata_en2, ddr_rdata_en3, ddr_rdata_en4;
    logic                 ddr_rdone1, ddr_rdone2, ddr_rdone3, ddr_rdone4;
    logic                 cmd_req;
    logic                 cmd_rrdy;
    logic                 cmd_rdata_vld;
    logic                 cmd_rdone;
    logic                 arb_err;

    modport master (
        input  rreq1, rreq2, rreq3, rreq4, ddr_rd_len,
        input  cmd_rrdy, cmd_rdata_vld, cmd_rdone,
        output rd_opera_en_1, rd_opera_en_2, rd_opera_en_3, rd_opera_en_4,
        output ddr_rdata_en1, ddr_rdata_en2, ddr_rdata_en3, ddr_rdata_en4,
        output ddr_rdone1, ddr_rdone2, ddr_rdone3, ddr_rdone4,
        output cmd_req, arb_err
    );

    modport slave (
        output rreq1, rreq2, rreq3, rreq4, ddr_rd_len,
        output cmd_rrdy, cmd_rdata_vld, cmd_rdone,
        input  rd_opera_en_1, rd_opera_en_2, rd_opera_en_3, rd_opera_en_4,
        input  ddr_rdata_en1, ddr_rdata_en2, ddr_rdata_en3, ddr_rdata_en4,
        input  ddr_rdone1, ddr_rdone2, ddr_rdone3, ddr_rdone4,
        input  cmd_req, arb_err
    );

endinterface
`default_nettype wire

// File: rtl/rd_arbiter_rr_grant4.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant4
// Description : 4-way round-robin picker. Searches the request vector
//               starting at index i_ptr and wrapping; returns a one-hot
//               grant, or zero when nothing is requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant4 (
    input  wire logic [3:0] i_req,
    input  wire logic [1:0] i_ptr,
    output logic      [3:0] o_gnt
);

    // Walk offsets from far to near so the nearest requester wins last
    always_comb begin
        logic [1:0] w_idx;
        w_idx = '0;
        o_gnt = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_gnt = 4'b0001 << w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rd_arbiter
// Description : Round-robin read arbiter for four read requesters sharing
//               one DDR controller port. Issues the command, steers data
//               strobes and done pulses to the granted requester, checks
//               the received beat count and aborts stalled bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_arbiter
    import rd_arbiter_pkg::*;
#(
    parameter int LEN_WIDTH = c_LEN_WIDTH,
    parameter int TIMEOUT   = 4096
) (
    input wire logic     ddr_clk,
    input wire logic     ddr_rst,
    rd_arbiter_if.master bus
);

    localparam int                   c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [LEN_WIDTH-1:0] c_BEAT_MAX = '1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_armed;
    logic [1:0]           r_ptr;
    logic [3:0]           r_gnt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_beats;
    logic [c_TMO_W-1:0]   r_tmo;
    logic                 r_err;

    logic [3:0]           w_req;
    logic [3:0]           w_rr_gnt;
    logic                 w_grant;
    logic                 w_done;
    logic                 w_tmo_abort;
    logic                 w_in_burst;
    logic                 w_beat_inc;
    logic [LEN_WIDTH-1:0] w_beats_fin;

    assign w_req = {bus.rreq4, bus.rreq3, bus.rreq2, bus.rreq1};

    rr_grant4 u_rr_grant4 (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt)
    );

    assign w_in_burst  = (r_state != ST_IDLE);
    // A beat arriving together with cmd_rdone still counts toward the total
    assign w_beat_inc  = w_in_burst && bus.cmd_rdata_vld && (r_beats != c_BEAT_MAX);
    assign w_beats_fin = r_beats + LEN_WIDTH'(w_beat_inc);

    // Next-state decode; controller strobes in IDLE are deliberately ignored
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_tmo_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && (|w_req)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.cmd_rdone) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.cmd_rrdy) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.cmd_rdone) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_tmo_abort = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hold off arbitration for the first edge after reset release
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Grant, round-robin pointer and burst length, captured at the grant edge
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_gnt <= '0;
            r_ptr <= '0;
            r_len <= '0;
        end else if (w_grant) begin
            r_gnt <= w_rr_gnt;
            r_ptr <= onehot_to_idx(w_rr_gnt) + 2'd1;
            r_len <= bus.ddr_rd_len;
        end else if (w_done || w_tmo_abort) begin
            r_gnt <= '0;
        end
    end

    // Saturating beat counter for the current burst
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_beats <= '0;
        end else if (w_grant) begin
            r_beats <= '0;
        end else if (w_beat_inc) begin
            r_beats <= r_beats + 1'b1;
        end
    end

    // Data-phase watchdog: restarts on entry to DATA, advances every DATA cycle
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_tmo <= '0;
        end else if ((r_state == ST_REQ) && (w_state_nxt == ST_DATA)) begin
            r_tmo <= '0;
        end else if ((r_state == ST_DATA) && (w_state_nxt == ST_DATA)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Sticky error on length mismatch at completion or on a stalled burst
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_err <= 1'b0;
        end else if ((w_done && (w_beats_fin != r_len)) || w_tmo_abort) begin
            r_err <= 1'b1;
        end
    end

    assign bus.rd_opera_en_1 = r_gnt[0];
    assign bus.rd_opera_en_2 = r_gnt[1];
    assign bus.rd_opera_en_3 = r_gnt[2];
    assign bus.rd_opera_en_4 = r_gnt[3];

    assign bus.ddr_rdata_en1 = r_gnt[0] & bus.cmd_rdata_vld;
    assign bus.ddr_rdata_en2 = r_gnt[1] & bus.cmd_rdata_vld;
    assign bus.ddr_rdata_en3 = r_gnt[2] & bus.cmd_rdata_vld;
    assign bus.ddr_rdata_en4 = r_gnt[3] & bus.cmd_rdata_vld;

    assign bus.ddr_rdone1 = r_gnt[0] & bus.cmd_rdone & w_in_burst;
    assign bus.ddr_rdone2 = r_gnt[1] & bus.cmd_rdone & w_in_burst;
    assign bus.ddr_rdone3 = r_gnt[2] & bus.cmd_rdone & w_in_burst;
    assign bus.ddr_rdone4 = r_gnt[3] & bus.cmd_rdone & w_in_burst;

    assign bus.cmd_req = (r_state == ST_REQ);
    assign bus.arb_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_arbiter
// Description : Self-checking bench for rd_arbiter: a table of scripted
//               bursts, hand-written corner sequences (reset release,
//               idle noise, dropped request, timeout, mid-burst reset) and
//               random bursts checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_arbiter;

    localparam int c_LW  = 16;
    localparam int c_TMO = 16;

    typedef struct {
        logic [3:0] reqs;
        logic [3:0] drop;
        int         len;
        int         dly;
        int         beats;
        int         mode;     // 0 normal, 1 rrdy+rdone together in REQ, 2 no rdone
        logic [3:0] exp_gnt;
        bit         exp_err;
    } vec_t;

    logic ddr_clk = 1'b0;
    logic ddr_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_ptr = 0;      // model: index where the next search starts
    bit   m_err = 1'b0;   // model: sticky error

    always #5 ddr_clk = ~ddr_clk;

    rd_arbiter_if #(.LEN_WIDTH(c_LW)) bus ();

    rd_arbiter #(
        .LEN_WIDTH (c_LW),
        .TIMEOUT   (c_TMO)
    ) dut (
        .ddr_clk (ddr_clk),
        .ddr_rst (ddr_rst),
        .bus     (bus)
    );

    function automatic logic [3:0] gnt_vec();
        return {bus.rd_opera_en_4, bus.rd_opera_en_3, bus.rd_opera_en_2, bus.rd_opera_en_1};
    endfunction

    function automatic logic [3:0] rdata_vec();
        return {bus.ddr_rdata_en4, bus.ddr_rdata_en3, bus.ddr_rdata_en2, bus.ddr_rdata_en1};
    endfunction

    function automatic logic [3:0] rdone_vec();
        return {bus.ddr_rdone4, bus.ddr_rdone3, bus.ddr_rdone2, bus.ddr_rdone1};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic set_reqs(input logic [3:0] r);
        bus.rreq1 = r[0];
        bus.rreq2 = r[1];
        bus.rreq3 = r[2];
        bus.rreq4 = r[3];
    endtask

    task automatic clear_cmd();
        bus.cmd_rrdy      = 1'b0;
        bus.cmd_rdata_vld = 1'b0;
        bus.cmd_rdone     = 1'b0;
    endtask

    task automatic do_reset();
        ddr_rst = 1'b1;
        set_reqs(4'b0000);
        clear_cmd();
        bus.ddr_rd_len = '0;
        #1;
        check("rst_gnt", 32'(gnt_vec()), 32'd0);
        check("rst_cmd_req", 32'(bus.cmd_req), 32'd0);
        check("rst_err", 32'(bus.arb_err), 32'd0);
        repeat (2) @(posedge ddr_clk);
        #1;
        ddr_rst = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // Round-robin from the model pointer; the pointer moves past the winner
    function automatic logic [3:0] model_grant(input logic [3:0] reqs);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (reqs[idx]) begin
                m_ptr = (idx + 1) % 4;
                return 4'b0001 << idx;
            end
        end
        return 4'b0000;
    endfunction

    // One burst from IDLE: request, grant, command handshake, beats, end
    task automatic run_burst(input string nm, input logic [3:0] reqs, input logic [3:0] drop,
                             input int len, input int dly, input int beats, input int mode,
                             input bit lwd, input logic [3:0] exp_gnt, input bit exp_err);
        int dcyc;
        int sent;
        int data_beats;
        set_reqs(reqs);
        bus.ddr_rd_len = c_LW'(len);
        clear_cmd();
        #1;
        check({nm, "_idle_gnt"}, 32'(gnt_vec()), 32'd0);
        tick();
        check({nm, "_gnt"}, 32'(gnt_vec()), 32'(exp_gnt));
        check({nm, "_cmd_req"}, 32'(bus.cmd_req), 32'd1);
        bus.ddr_rd_len = c_LW'($urandom);
        set_reqs(reqs & ~drop);
        for (int d = 0; d < dly; d++) begin
            tick();
            check({nm, "_cmd_hold"}, 32'(bus.cmd_req), 32'd1);
        end
        if (mode == 1) begin
            bus.cmd_rrdy      = 1'b1;
            bus.cmd_rdone     = 1'b1;
            bus.cmd_rdata_vld = (beats > 0);
            #1;
            check({nm, "_rdone"}, 32'(rdone_vec()), 32'(exp_gnt));
            check({nm, "_rdata"}, 32'(rdata_vec()), (beats > 0) ? 32'(exp_gnt) : 32'd0);
            tick();
            clear_cmd();
        end else begin
            bus.cmd_rrdy = 1'b1;
            tick();
            bus.cmd_rrdy = 1'b0;
            check({nm, "_cmd_drop"}, 32'(bus.cmd_req), 32'd0);
            dcyc = 0;
            sent = 0;
            data_beats = (mode == 0 && lwd && beats > 0) ? beats - 1 : beats;
            while (sent < data_beats) begin
                if (mode == 0 && dcyc < 4 && $urandom_range(0, 3) == 0) begin
                    tick();
                    dcyc++;
                end else begin
                    bus.cmd_rdata_vld = 1'b1;
                    #1;
                    check({nm, "_rdata"}, 32'(rdata_vec()), 32'(exp_gnt));
                    tick();
                    bus.cmd_rdata_vld = 1'b0;
                    dcyc++;
                    sent++;
                end
            end
            if (mode == 0) begin
                bus.cmd_rdone     = 1'b1;
                bus.cmd_rdata_vld = (data_beats != beats);
                #1;
                check({nm, "_rdone"}, 32'(rdone_vec()), 32'(exp_gnt));
                tick();
                clear_cmd();
            end else begin
                while (gnt_vec() != 4'b0000 && dcyc < c_TMO + 4) begin
                    check({nm, "_no_rdone"}, 32'(rdone_vec()), 32'd0);
                    tick();
                    dcyc++;
                end
                check({nm, "_tmo_cycles"}, 32'(dcyc), 32'(c_TMO));
            end
        end
        check({nm, "_end_gnt"}, 32'(gnt_vec()), 32'd0);
        check({nm, "_end_cmd_req"}, 32'(bus.cmd_req), 32'd0);
        check({nm, "_err"}, 32'(bus.arb_err), 32'(exp_err));
    endtask

    // Burst whose expected grant and error come from the model
    task automatic run_model_burst(input string nm, input logic [3:0] reqs, input logic [3:0] drop,
                                   input int len, input int dly, input int beats, input int mode,
                                   input bit lwd);
        logic [3:0] exp_gnt;
        exp_gnt = model_grant(reqs);
        if (mode == 2 || beats != len) begin
            m_err = 1'b1;
        end
        run_burst(nm, reqs, drop & reqs & ~exp_gnt, len, dly, beats, mode, lwd, exp_gnt, m_err);
    endtask

    initial begin
        vec_t tbl [10];
        tbl[0] = '{4'b1111, 4'b0000, 4, 1, 4, 0, 4'b0001, 1'b0};
        tbl[1] = '{4'b1111, 4'b0000, 4, 0, 4, 0, 4'b0010, 1'b0};
        tbl[2] = '{4'b1111, 4'b0000, 4, 1, 4, 0, 4'b0100, 1'b0};
        tbl[3] = '{4'b1111, 4'b0000, 4, 0, 4, 0, 4'b1000, 1'b0};
        tbl[4] = '{4'b1111, 4'b0000, 4, 2, 4, 0, 4'b0001, 1'b0};
        tbl[5] = '{4'b0001, 4'b0000, 8, 2, 8, 0, 4'b0001, 1'b0};
        tbl[6] = '{4'b0100, 4'b0000, 1, 0, 1, 1, 4'b0100, 1'b0};
        tbl[7] = '{4'b1001, 4'b0000, 8, 1, 7, 0, 4'b1000, 1'b1};
        tbl[8] = '{4'b0110, 4'b0000, 3, 0, 3, 0, 4'b0010, 1'b1};
        tbl[9] = '{4'b0011, 4'b0000, 2, 1, 2, 0, 4'b0001, 1'b1};

        do_reset();
        tick();
        for (int i = 0; i < 10; i++) begin
            run_burst($sformatf("tbl%0d", i), tbl[i].reqs, tbl[i].drop, tbl[i].len, tbl[i].dly,
                      tbl[i].beats, tbl[i].mode, 1'b0, tbl[i].exp_gnt, tbl[i].exp_err);
        end

        // Request held across reset release: no grant at the first edge
        do_reset();
        set_reqs(4'b0001);
        tick();
        check("first_edge_gnt", 32'(gnt_vec()), 32'd0);
        run_model_burst("rst_release", 4'b0001, 4'b0000, 2, 0, 2, 0, 1'b0);

        // Controller strobes while IDLE are ignored
        set_reqs(4'b0000);
        bus.cmd_rdone     = 1'b1;
        bus.cmd_rdata_vld = 1'b1;
        #1;
        check("idle_rdone", 32'(rdone_vec()), 32'd0);
        check("idle_rdata", 32'(rdata_vec()), 32'd0);
        repeat (2) tick();
        clear_cmd();
        check("idle_err", 32'(bus.arb_err), 32'd0);
        check("idle_gnt", 32'(gnt_vec()), 32'd0);

        // Requester 3 withdraws while requester 2 is served
        run_model_burst("drop_a", 4'b0110, 4'b0100, 3, 1, 3, 0, 1'b1);
        run_model_burst("drop_b", 4'b0001, 4'b0000, 2, 0, 2, 0, 1'b0);

        // Stalled burst, then a normal one is still served
        run_model_burst("tmo", 4'b0100, 4'b0000, 2, 1, 2, 2, 1'b0);
        run_model_burst("after_tmo", 4'b1000, 4'b0000, 3, 0, 3, 0, 1'b0);

        // Reset in the data phase of requester 3 clears outputs without an edge
        set_reqs(4'b0100);
        bus.ddr_rd_len = 16'd4;
        #1;
        tick();
        check("mid_gnt", 32'(gnt_vec()), 32'b0100);
        bus.cmd_rrdy = 1'b1;
        tick();
        bus.cmd_rrdy      = 1'b0;
        bus.cmd_rdata_vld = 1'b1;
        #1;
        check("mid_rdata", 32'(rdata_vec()), 32'b0100);
        ddr_rst = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt_vec()), 32'd0);
        check("mid_rst_rdata", 32'(rdata_vec()), 32'd0);
        check("mid_rst_cmd_req", 32'(bus.cmd_req), 32'd0);
        check("mid_rst_err", 32'(bus.arb_err), 32'd0);
        bus.cmd_rdone = 1'b1;
        #1;
        check("mid_rst_rdone", 32'(rdone_vec()), 32'd0);
        clear_cmd();
        set_reqs(4'b0000);
        repeat (2) @(posedge ddr_clk);
        #1;
        ddr_rst = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        tick();
        run_model_burst("post_rst", 4'b1111, 4'b0000, 2, 0, 2, 0, 1'b0);

        // Random bursts against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rq;
            int         len;
            int         beats;
            int         mode;
            int         dly;
            bit         lwd;
            rq   = 4'($urandom_range(1, 15));
            mode = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 6) == 0) ? 1 : 0);
            if (mode == 1) begin
                len   = 1;
                beats = $urandom_range(0, 1);
            end else begin
                len   = $urandom_range(1, 6);
                beats = ($urandom_range(0, 4) == 0) ? len + 2 * $urandom_range(0, 1) - 1 : len;
            end
            dly = $urandom_range(0, 3);
            lwd = 1'($urandom_range(0, 1));
            run_model_burst($sformatf("rnd%0d", i), rq, 4'($urandom), len, dly, beats, mode, lwd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
